// File: rtl/mem_lsu.sv
// Load/store initiator for the physical-memory port: one request at a time,
// split into two aligned beats when the access straddles an 8-byte boundary.
module mem_lsu #(
   parameter logic [63:0] RESET_ADDR = 64'h8000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [63:0] req_addr_i,
   input  logic [63:0] req_wdata_i,
   input  logic [1:0]  req_size_i,
   input  logic        req_unsigned_i,
   output logic        resp_valid_o,
   output logic [63:0] resp_rdata_o,
   output logic [63:0] mem_raddr_o,
   input  logic [63:0] mem_rdata_i,
   output logic [63:0] mem_waddr_o,
   output logic [63:0] mem_wdata_o,
   output logic [7:0]  mem_wmask_o,
   output logic [1:0]  dbg_state_o
);

   // Handshake: a request transfers on a rising edge where req_valid_i and
   // req_ready_o are both high; resp_valid_o is a single-cycle pulse with no backpressure.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BEAT0 = 2'd1,
      S_BEAT1 = 2'd2,
      S_RESP  = 2'd3
   } state_e;

   state_e      state_q, state_d;
   logic [2:0]  off_q, off_d;
   logic [1:0]  size_q, size_d;
   logic        we_q, we_d;
   logic        uns_q, uns_d;
   logic        cross_q, cross_d;
   logic [63:0] base_q, base_d;
   logic [63:0] addr_q, addr_d;
   logic [63:0] wdata_q, wdata_d;
   logic [63:0] wdata_hi_q, wdata_hi_d;
   logic [63:0] lo_q, lo_d;
   logic [63:0] hi_q, hi_d;

   logic [3:0]  req_n;
   logic [7:0]  size_mask;
   logic [15:0] lane_mask;
   logic [63:0] sh_data;
   logic [63:0] load_ext;

   assign req_n = 4'd1 << req_size_i;

   // Byte-lane mask of the access spread across both beats: low byte for
   // BEAT0, high byte for BEAT1.
   always_comb begin
      size_mask = 8'h00;
      case (size_q)
         2'd0:    size_mask = 8'h01;
         2'd1:    size_mask = 8'h03;
         2'd2:    size_mask = 8'h0F;
         default: size_mask = 8'hFF;
      endcase
      lane_mask = {8'h00, size_mask} << off_q;
   end

   always_comb begin
      sh_data  = 64'({hi_q, lo_q} >> {off_q, 3'b000});
      load_ext = sh_data;
      case (size_q)
         2'd0:    load_ext = uns_q ? {56'd0, sh_data[7:0]}  : {{56{sh_data[7]}},  sh_data[7:0]};
         2'd1:    load_ext = uns_q ? {48'd0, sh_data[15:0]} : {{48{sh_data[15]}}, sh_data[15:0]};
         2'd2:    load_ext = uns_q ? {32'd0, sh_data[31:0]} : {{32{sh_data[31]}}, sh_data[31:0]};
         default: load_ext = sh_data;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      off_d        = off_q;
      size_d       = size_q;
      we_d         = we_q;
      uns_d        = uns_q;
      cross_d      = cross_q;
      base_d       = base_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      wdata_hi_d   = wdata_hi_q;
      lo_d         = lo_q;
      hi_d         = hi_q;
      req_ready_o  = 1'b0;
      resp_valid_o = 1'b0;
      resp_rdata_o = 64'd0;
      mem_wmask_o  = 8'h00;

      case (state_q)
         S_IDLE: begin
            req_ready_o = 1'b1;
            if (req_valid_i) begin
               off_d   = req_addr_i[2:0];
               size_d  = req_size_i;
               we_d    = req_we_i;
               uns_d   = req_unsigned_i;
               cross_d = ({1'b0, req_addr_i[2:0]} + req_n) > 4'd8;
               base_d  = {req_addr_i[63:3], 3'b000};
               addr_d  = {req_addr_i[63:3], 3'b000};
               hi_d    = 64'd0;
               if (req_we_i) begin
                  {wdata_hi_d, wdata_d} = {64'd0, req_wdata_i} << {req_addr_i[2:0], 3'b000};
               end
               state_d = S_BEAT0;
            end
         end
         S_BEAT0: begin
            if (we_q) begin
               mem_wmask_o = lane_mask[7:0];
            end else begin
               lo_d = mem_rdata_i;
            end
            if (cross_q) begin
               addr_d  = base_q + 64'd8;
               if (we_q) begin
                  wdata_d = wdata_hi_q;
               end
               state_d = S_BEAT1;
            end else begin
               state_d = S_RESP;
            end
         end
         S_BEAT1: begin
            if (we_q) begin
               mem_wmask_o = lane_mask[15:8];
            end else begin
               hi_d = mem_rdata_i;
            end
            state_d = S_RESP;
         end
         default: begin
            resp_valid_o = 1'b1;
            if (!we_q) begin
               resp_rdata_o = load_ext;
            end
            state_d = S_IDLE;
         end
      endcase

      // A reset edge must not commit the beat it interrupts.
      if (rst_i) begin
         mem_wmask_o = 8'h00;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         off_q      <= 3'd0;
         size_q     <= 2'd0;
         we_q       <= 1'b0;
         uns_q      <= 1'b0;
         cross_q    <= 1'b0;
         base_q     <= RESET_ADDR;
         addr_q     <= RESET_ADDR;
         wdata_q    <= 64'd0;
         wdata_hi_q <= 64'd0;
         lo_q       <= 64'd0;
         hi_q       <= 64'd0;
      end else begin
         state_q    <= state_d;
         off_q      <= off_d;
         size_q     <= size_d;
         we_q       <= we_d;
         uns_q      <= uns_d;
         cross_q    <= cross_d;
         base_q     <= base_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         wdata_hi_q <= wdata_hi_d;
         lo_q       <= lo_d;
         hi_q       <= hi_d;
      end
   end

   assign mem_raddr_o = addr_q;
   assign mem_waddr_o = addr_q;
   assign mem_wdata_o = wdata_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu with a 64-byte responder memory model mapped at 0x8000_0000.
module tb_mem_lsu;

   localparam logic [63:0] RST_A = 64'h8000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic        resp_valid;
   logic [63:0] resp_rdata;
   logic [63:0] mem_raddr;
   logic [63:0] mem_rdata;
   logic [63:0] mem_waddr;
   logic [63:0] mem_wdata;
   logic [7:0]  mem_wmask;
   logic [1:0]  dbg_state;

   logic [7:0]  mem [0:63];
   logic        poke_en;
   logic [5:0]  poke_idx;
   logic [7:0]  poke_val;

   int checks = 0;
   int errors = 0;

   mem_lsu #(.RESET_ADDR(RST_A)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .req_valid_i    (req_valid),
      .req_ready_o    (req_ready),
      .req_we_i       (req_we),
      .req_addr_i     (req_addr),
      .req_wdata_i    (req_wdata),
      .req_size_i     (req_size),
      .req_unsigned_i (req_unsigned),
      .resp_valid_o   (resp_valid),
      .resp_rdata_o   (resp_rdata),
      .mem_raddr_o    (mem_raddr),
      .mem_rdata_i    (mem_rdata),
      .mem_waddr_o    (mem_waddr),
      .mem_wdata_o    (mem_wdata),
      .mem_wmask_o    (mem_wmask),
      .dbg_state_o    (dbg_state)
   );

   always #5 clk = ~clk;

   // Responder: combinational read, byte-lane write on the clock edge.
   always @(posedge clk) begin
      if (poke_en) mem[poke_idx] <= poke_val;
      for (int i = 0; i < 8; i++) begin
         if (mem_wmask[i]) mem[mem_waddr[5:0] + 6'(i)] <= mem_wdata[8*i +: 8];
      end
   end

   always_comb begin
      mem_rdata = 64'd0;
      for (int i = 0; i < 8; i++) begin
         mem_rdata[8*i +: 8] = mem[mem_raddr[5:0] + 6'(i)];
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic poke(input logic [5:0] idx, input logic [7:0] val);
      poke_en  = 1'b1;
      poke_idx = idx;
      poke_val = val;
      step();
      poke_en  = 1'b0;
   endtask

   // Returns positioned in the BEAT0 cycle (#1 after the accept edge).
   task automatic issue(input logic we, input logic [63:0] addr, input logic [63:0] wd,
                        input logic [1:0] sz, input logic uns);
      int k;
      k = 0;
      while (!req_ready && k < 20) begin
         step();
         k++;
      end
      chk("accept_ready", {63'd0, req_ready}, 64'd1);
      req_we       = we;
      req_addr     = addr;
      req_wdata    = wd;
      req_size     = sz;
      req_unsigned = uns;
      req_valid    = 1'b1;
      step();
      req_valid    = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 64'd0;
      req_wdata = 64'd0; req_size = 2'd0; req_unsigned = 1'b0;
      poke_en = 1'b0; poke_idx = 6'd0; poke_val = 8'd0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Idle after reset
      chk("rst_waddr", mem_waddr, RST_A);
      chk("rst_wdata", mem_wdata, 64'd0);
      chk("rst_rdata", resp_rdata, 64'd0);
      for (int c = 0; c < 5; c++) begin
         chk("idle_wmask", {56'd0, mem_wmask}, 64'd0);
         chk("idle_raddr", mem_raddr, RST_A);
         chk("idle_ready", {63'd0, req_ready}, 64'd1);
         chk("idle_resp_valid", {63'd0, resp_valid}, 64'd0);
         step();
      end

      // Aligned dword load
      poke(6'd16, 8'h88); poke(6'd17, 8'h77); poke(6'd18, 8'h66); poke(6'd19, 8'h55);
      poke(6'd20, 8'h44); poke(6'd21, 8'h33); poke(6'd22, 8'h22); poke(6'd23, 8'h11);
      issue(1'b0, 64'h8000_0010, 64'd0, 2'd3, 1'b0);
      chk("ld64_b0_raddr", mem_raddr, 64'h8000_0010);
      chk("ld64_b0_wmask", {56'd0, mem_wmask}, 64'd0);
      chk("ld64_b0_resp_valid", {63'd0, resp_valid}, 64'd0);
      step();
      chk("ld64_resp_valid", {63'd0, resp_valid}, 64'd1);
      chk("ld64_rdata", resp_rdata, 64'h1122_3344_5566_7788);
      step();
      chk("ld64_after_valid", {63'd0, resp_valid}, 64'd0);
      chk("ld64_after_ready", {63'd0, req_ready}, 64'd1);

      // Byte load at lane 7, signed then unsigned
      poke(6'd7, 8'h80);
      issue(1'b0, 64'h8000_0007, 64'd0, 2'd0, 1'b0);
      chk("ldb_b0_raddr", mem_raddr, 64'h8000_0000);
      step();
      chk("ldb_s_resp_valid", {63'd0, resp_valid}, 64'd1);
      chk("ldb_s_rdata", resp_rdata, 64'hFFFF_FFFF_FFFF_FF80);
      step();
      issue(1'b0, 64'h8000_0007, 64'd0, 2'd0, 1'b1);
      step();
      chk("ldb_u_rdata", resp_rdata, 64'h0000_0000_0000_0080);
      step();

      // Crossing word store
      issue(1'b1, 64'h8000_0006, 64'h0000_0000_DEAD_BEEF, 2'd2, 1'b0);
      chk("stw_b0_waddr", mem_waddr, 64'h8000_0000);
      chk("stw_b0_wmask", {56'd0, mem_wmask}, 64'hC0);
      chk("stw_b0_wdata_hi", {48'd0, mem_wdata[63:48]}, 64'hBEEF);
      step();
      chk("stw_b1_waddr", mem_waddr, 64'h8000_0008);
      chk("stw_b1_wmask", {56'd0, mem_wmask}, 64'h03);
      chk("stw_b1_wdata_lo", {48'd0, mem_wdata[15:0]}, 64'hDEAD);
      chk("stw_b1_resp_valid", {63'd0, resp_valid}, 64'd0);
      step();
      chk("stw_resp_valid", {63'd0, resp_valid}, 64'd1);
      chk("stw_rdata", resp_rdata, 64'd0);
      chk("stw_resp_wmask", {56'd0, mem_wmask}, 64'd0);
      step();

      // Crossing word load of the value just stored
      issue(1'b0, 64'h8000_0006, 64'd0, 2'd2, 1'b0);
      step();
      chk("ldw_b1_raddr", mem_raddr, 64'h8000_0008);
      chk("ldw_b1_resp_valid", {63'd0, resp_valid}, 64'd0);
      step();
      chk("ldw_resp_valid", {63'd0, resp_valid}, 64'd1);
      chk("ldw_rdata", resp_rdata, 64'hFFFF_FFFF_DEAD_BEEF);
      step();

      // Single-beat half store
      issue(1'b1, 64'h8000_0002, 64'h0000_0000_0000_ABCD, 2'd1, 1'b0);
      chk("sth_b0_wmask", {56'd0, mem_wmask}, 64'h0C);
      chk("sth_b0_wdata", mem_wdata, 64'h0000_0000_ABCD_0000);
      step();
      chk("sth_resp_valid", {63'd0, resp_valid}, 64'd1);
      chk("sth_rdata", resp_rdata, 64'd0);
      step();
      chk("sth_mem2", {56'd0, mem[2]}, 64'hCD);
      chk("sth_mem3", {56'd0, mem[3]}, 64'hAB);

      // Reset during BEAT1 of a crossing store
      issue(1'b1, 64'h8000_0006, 64'h0000_0000_1122_3344, 2'd2, 1'b0);
      chk("rstw_b0_wmask", {56'd0, mem_wmask}, 64'hC0);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rstw_resp_valid", {63'd0, resp_valid}, 64'd0);
      chk("rstw_wmask", {56'd0, mem_wmask}, 64'd0);
      chk("rstw_ready", {63'd0, req_ready}, 64'd1);
      chk("rstw_raddr", mem_raddr, RST_A);
      chk("rstw_wdata", mem_wdata, 64'd0);
      step();
      chk("rstw_resp_valid2", {63'd0, resp_valid}, 64'd0);
      chk("rstw_mem6", {56'd0, mem[6]}, 64'h44);
      chk("rstw_mem7", {56'd0, mem[7]}, 64'h33);
      chk("rstw_mem8", {56'd0, mem[8]}, 64'hAD);
      chk("rstw_mem9", {56'd0, mem[9]}, 64'hDE);

      // Crossing unsigned half load spanning lanes 7 and 8
      issue(1'b0, 64'h8000_0007, 64'd0, 2'd1, 1'b1);
      step();
      step();
      chk("ldh_x_resp_valid", {63'd0, resp_valid}, 64'd1);
      chk("ldh_x_rdata", resp_rdata, 64'h0000_0000_0000_AD33);
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
